keypad_scanner: RTL and testbench
=================================

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 5000, meaning clk cycles per column period (10 kHz at 50 MHz).
REQ-002 SHALL have parameter DEBOUNCE_FRAMES, default 8, meaning consecutive identical full-scan frames needed to accept a press or release.
REQ-003 SHALL have parameter REPEAT_DELAY, default 60, meaning frames from accept to first auto-repeat.
REQ-004 SHALL have parameter REPEAT_RATE, default 12, meaning frames between later auto-repeats.
REQ-005 SHALL have port clk, input, 1 bit, meaning the single system clock; all logic is on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit, meaning the reset; it is synchronous and active-high.
REQ-007 SHALL have port rows, input, 4 bits, meaning keypad row lines; active-low, externally pulled up, asynchronous.
REQ-008 SHALL have port cols, output, 4 bits, meaning column drives; active-low, exactly one bit low at any time.
REQ-009 SHALL have port key_code, output, 4 bits, meaning code of the accepted key = row_index*4 + col_index.
REQ-010 SHALL have port key_valid, output, 1 bit, meaning a one-clk pulse when key_code is newly valid.
REQ-011 SHALL have port key_held, output, 1 bit, meaning high while an accepted key is held.

Function
REQ-012 SHALL pass rows through a 2-flop synchronizer before any use.
REQ-013 SHALL generate scan_tick for one clk every SCAN_DIV clks from a counter that wraps SCAN_DIV-1 -> 0.
REQ-014 SHALL rotate cols 1110 -> 1101 -> 1011 -> 0111 -> 1110 on the clk after each scan_tick.
REQ-015 SHALL sample the synchronized rows for the active column on the scan_tick clk, before the column advances.
REQ-016 SHALL end a frame on the scan_tick of column 3, classifying it as NONE (0 keys), SINGLE (exactly 1 key, with its code) or MULTI (2 or more keys).
REQ-017 SHALL implement FSM states IDLE, DEB_PRESS, PRESSED and DEB_RELEASE, evaluated only at frame end.
REQ-018 SHALL transition IDLE -> DEB_PRESS on a SINGLE frame, latching the candidate code and setting the match count to 1.
REQ-019 SHALL, in DEB_PRESS, increment the count on a SINGLE frame with the same code; reaching DEBOUNCE_FRAMES -> PRESSED.
REQ-020 SHALL, in DEB_PRESS, return to IDLE on a NONE or MULTI frame, and restart with count 1 on a SINGLE frame with a different code.
REQ-021 SHALL, on DEB_PRESS -> PRESSED, load key_code with the candidate and pulse key_valid on the next clk; key_held rises on the same clk.
REQ-022 SHALL, in PRESSED, go to DEB_RELEASE with count 1 on a NONE frame; SINGLE-same and MULTI frames hold PRESSED.
REQ-023 SHALL, in DEB_RELEASE, increment the count on a NONE frame; reaching DEBOUNCE_FRAMES -> IDLE, key_held falls, and key_code holds its last value.
REQ-024 SHALL, in DEB_RELEASE, return to PRESSED on any non-NONE frame.
REQ-025 SHALL saturate all counters at their terminal values; there is no wrap beyond a terminal value.
REQ-026 SHALL never pulse key_valid on two consecutive clks.

Reset
REQ-027 SHALL, when reset is high on a clk edge, set cols=1110, key_code=0, key_valid=0, key_held=0, clear all counters and synchronizer flops, and set the state to IDLE.
REQ-028 SHALL treat reset asserted mid-press or mid-frame as overriding all other activity, with no key_valid for the aborted press; scanning restarts at column 0.

Configuration
REQ-029 SHALL, with macro KEYPAD_AUTOREPEAT_EN defined, re-pulse key_valid (same key_code) while in PRESSED: first after REPEAT_DELAY frames from accept, then every REPEAT_RATE frames; the repeat counter clears on leaving PRESSED.
REQ-030 SHALL, with KEYPAD_AUTOREPEAT_EN undefined, produce exactly one key_valid per accepted press and contain no repeat logic.

Verification (SCAN_DIV=4, DEBOUNCE_FRAMES=3, REPEAT_DELAY=4, REPEAT_RATE=2; frame = 16 clks)
REQ-031 SHALL cover: reset, no keys -> cols cycle 1110, 1101, 1011, 0111 every 4 clks; key_valid never asserts; key_held=0.
REQ-032 SHALL cover: row1 held low while cols=1011 (key 6) for 4 frames -> exactly one key_valid, key_code=6, key_held=1 until 3 NONE frames after release.
REQ-033 SHALL cover: key 6 bounces (SINGLE, NONE, SINGLE, SINGLE, SINGLE) -> key_valid asserts only after the last 3 SINGLE frames.
REQ-034 SHALL cover: keys 0 and 5 pressed together -> MULTI frames, no key_valid; release key 5 -> key_valid with key_code=0 after 3 frames.
REQ-035 SHALL cover: reset pulsed during DEB_PRESS at count 2 -> no key_valid, cols=1110 on the next clk.
REQ-036 SHALL cover: KEYPAD_AUTOREPEAT_EN defined, key 15 held 12 frames -> key_valid pulses at accept, at accept+4 frames, then every 2 frames; with the macro undefined, exactly one pulse.

Source files
------------

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 matrix keypad scanner with frame-based debounce.
// Optional auto-repeat of key_valid while held: define KEYPAD_AUTOREPEAT_EN.
module keypad_scanner #(
    parameter int SCAN_DIV        = 5000,
    parameter int DEBOUNCE_FRAMES = 8,
    parameter int REPEAT_DELAY    = 60,
    parameter int REPEAT_RATE     = 12
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] rows,
    output logic [3:0] cols,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam int DEB_W = $clog2(DEBOUNCE_FRAMES + 1);
    localparam logic [DEB_W-1:0] DEB_MAX = DEB_W'(DEBOUNCE_FRAMES);

    if (SCAN_DIV < 1 || DEBOUNCE_FRAMES < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_params
        $error("keypad_scanner: all parameters must be >= 1");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_DEB_PRESS,
        S_PRESSED,
        S_DEB_RELEASE
    } state_t;

    typedef enum logic [1:0] {
        F_NONE,
        F_SINGLE,
        F_MULTI
    } frame_t;

    logic [3:0]       r_rows_meta;
    logic [3:0]       r_rows_sync;
    logic [DIV_W-1:0] r_div_cnt;
    logic [1:0]       r_col_idx;
    logic [3:0]       r_cols;
    logic [1:0]       r_frame_hits;
    logic [3:0]       r_frame_code;
    state_t           r_state;
    logic [3:0]       r_cand;
    logic [DEB_W-1:0] r_deb_cnt;
    logic [3:0]       r_key_code;
    logic             r_key_valid;
    logic             r_key_held;

    logic             w_scan_tick;
    logic             w_frame_end;
    logic [3:0]       w_row_hit;
    logic [1:0]       w_col_hits;
    logic [1:0]       w_col_row;
    logic [1:0]       w_sum_hits;
    logic [3:0]       w_sum_code;
    frame_t           w_frame_class;
    logic [DEB_W-1:0] w_deb_inc;
    logic             w_deb_reach;
    logic             w_same_single;

    assign cols      = r_cols;
    assign key_code  = r_key_code;
    assign key_valid = r_key_valid;
    assign key_held  = r_key_held;

    // Synchronizer idles at all-ones, i.e. no row pulled low.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rows_meta <= 4'hF;
            r_rows_sync <= 4'hF;
        end else begin
            r_rows_meta <= rows;
            r_rows_sync <= r_rows_meta;
        end
    end

    assign w_scan_tick = (r_div_cnt == DIV_LAST);
    assign w_frame_end = w_scan_tick && (r_col_idx == 2'd3);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_div_cnt <= '0;
            r_col_idx <= 2'd0;
            r_cols    <= 4'b1110;
        end else if (w_scan_tick) begin
            r_div_cnt <= '0;
            r_col_idx <= r_col_idx + 2'd1;
            r_cols    <= {r_cols[2:0], r_cols[3]};
        end else begin
            r_div_cnt <= r_div_cnt + DIV_W'(1);
        end
    end

    // Per-column hit count saturates at 2; only the lowest pressed row matters for a single.
    assign w_row_hit = ~r_rows_sync;

    always_comb begin
        w_col_hits = 2'd0;
        w_col_row  = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (w_row_hit[i]) begin
                if (w_col_hits == 2'd0) begin
                    w_col_row = i[1:0];
                end
                if (w_col_hits != 2'd2) begin
                    w_col_hits = w_col_hits + 2'd1;
                end
            end
        end
    end

    always_comb begin
        w_sum_hits = 2'd2;
        if (r_frame_hits == 2'd0) begin
            w_sum_hits = w_col_hits;
        end else if (w_col_hits == 2'd0) begin
            w_sum_hits = r_frame_hits;
        end
        w_sum_code = r_frame_code;
        if (r_frame_hits == 2'd0 && w_col_hits == 2'd1) begin
            w_sum_code = {w_col_row, r_col_idx};
        end
    end

    always_comb begin
        w_frame_class = F_MULTI;
        if (w_sum_hits == 2'd0) begin
            w_frame_class = F_NONE;
        end else if (w_sum_hits == 2'd1) begin
            w_frame_class = F_SINGLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_frame_hits <= 2'd0;
            r_frame_code <= 4'd0;
        end else if (w_scan_tick) begin
            if (w_frame_end) begin
                r_frame_hits <= 2'd0;
                r_frame_code <= 4'd0;
            end else begin
                r_frame_hits <= w_sum_hits;
                r_frame_code <= w_sum_code;
            end
        end
    end

    assign w_deb_inc     = (r_deb_cnt == DEB_MAX) ? r_deb_cnt : r_deb_cnt + DEB_W'(1);
    assign w_deb_reach   = (w_deb_inc == DEB_MAX);
    assign w_same_single = (w_frame_class == F_SINGLE) && (w_sum_code == r_cand);

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int REP_W   = $clog2(REP_MAX + 1);
    localparam logic [REP_W-1:0] REP_MAX_C   = REP_W'(REP_MAX);
    localparam logic [REP_W-1:0] REP_DELAY_C = REP_W'(REPEAT_DELAY);
    localparam logic [REP_W-1:0] REP_RATE_C  = REP_W'(REPEAT_RATE);

    logic [REP_W-1:0] r_rep_cnt;
    logic             r_rep_phase;
    logic [REP_W-1:0] w_rep_inc;
    logic [REP_W-1:0] w_rep_limit;

    assign w_rep_inc   = (r_rep_cnt == REP_MAX_C) ? r_rep_cnt : r_rep_cnt + REP_W'(1);
    assign w_rep_limit = r_rep_phase ? REP_RATE_C : REP_DELAY_C;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cand      <= 4'd0;
            r_deb_cnt   <= '0;
            r_key_code  <= 4'd0;
            r_key_valid <= 1'b0;
            r_key_held  <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
            r_rep_cnt   <= '0;
            r_rep_phase <= 1'b0;
`endif
        end else begin
            r_key_valid <= 1'b0;
            if (w_frame_end) begin
                case (r_state)
                    S_IDLE: begin
                        if (w_frame_class == F_SINGLE) begin
                            r_state   <= S_DEB_PRESS;
                            r_cand    <= w_sum_code;
                            r_deb_cnt <= DEB_W'(1);
                        end
                    end
                    S_DEB_PRESS: begin
                        if (w_same_single) begin
                            if (w_deb_reach) begin
                                r_state     <= S_PRESSED;
                                r_deb_cnt   <= '0;
                                r_key_code  <= r_cand;
                                r_key_valid <= 1'b1;
                                r_key_held  <= 1'b1;
                            end else begin
                                r_deb_cnt <= w_deb_inc;
                            end
                        end else if (w_frame_class == F_SINGLE) begin
                            r_cand    <= w_sum_code;
                            r_deb_cnt <= DEB_W'(1);
                        end else begin
                            r_state   <= S_IDLE;
                            r_deb_cnt <= '0;
                        end
                    end
                    S_PRESSED: begin
                        if (w_frame_class == F_NONE) begin
                            r_state   <= S_DEB_RELEASE;
                            r_deb_cnt <= DEB_W'(1);
`ifdef KEYPAD_AUTOREPEAT_EN
                            r_rep_cnt   <= '0;
                            r_rep_phase <= 1'b0;
                        end else if (w_rep_inc == w_rep_limit) begin
                            r_key_valid <= 1'b1;
                            r_rep_cnt   <= '0;
                            r_rep_phase <= 1'b1;
                        end else begin
                            r_rep_cnt <= w_rep_inc;
`endif
                        end
                    end
                    S_DEB_RELEASE: begin
                        if (w_frame_class == F_NONE) begin
                            if (w_deb_reach) begin
                                r_state    <= S_IDLE;
                                r_deb_cnt  <= '0;
                                r_key_held <= 1'b0;
                            end else begin
                                r_deb_cnt <= w_deb_inc;
                            end
                        end else begin
                            r_state   <= S_PRESSED;
                            r_deb_cnt <= '0;
                        end
                    end
                    default: begin
                        r_state   <= S_IDLE;
                        r_deb_cnt <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - frame-level reference model and directed scenarios for keypad_scanner.
module tb_keypad_scanner;

    localparam int SD  = 4;
    localparam int DEB = 3;
    localparam int RD  = 4;
    localparam int RR  = 2;
    localparam int FRAME = 4 * SD;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] keys = 16'd0;
    logic [3:0]  rows;
    logic [3:0]  cols;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;

    int n_cmp = 0;
    int n_err = 0;
    int dut_pulses = 0;

    int       e = 0;
    bit       m_held = 0;
    bit       m_pulse = 0;
    int       m_code = 0;
    int       run_len = 0;
    int       run_code = 0;
    int       none_run = 0;
    int       rep_n = 0;

    keypad_scanner #(
        .SCAN_DIV(SD), .DEBOUNCE_FRAMES(DEB), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
    ) dut (
        .clk(clk), .reset(reset), .rows(rows), .cols(cols),
        .key_code(key_code), .key_valid(key_valid), .key_held(key_held)
    );

    always #5 clk = ~clk;

    // Physical matrix: a row reads low when a pressed key joins it to the driven-low column.
    always_comb begin
        rows = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !cols[c]) rows[r] = 1'b0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (edge %0d, t=%0t)", name, act, exp, e, $time);
        end
    endtask

    task automatic model_frame(input logic [15:0] mask);
        int cnt;
        int code;
        cnt  = $countones(mask);
        code = 0;
        for (int i = 15; i >= 0; i--) if (mask[i]) code = i;
        if (!m_held) begin
            if (cnt == 1) begin
                if (run_len > 0 && run_code == code) run_len++;
                else begin run_code = code; run_len = 1; end
                if (run_len >= DEB) begin
                    m_held = 1; m_code = run_code; m_pulse = 1;
                    run_len = 0; none_run = 0; rep_n = 0;
                end
            end else begin
                run_len = 0;
            end
        end else if (cnt == 0) begin
            none_run++;
            if (none_run >= DEB) begin m_held = 0; none_run = 0; run_len = 0; end
        end else if (none_run > 0) begin
            none_run = 0; rep_n = 0;
        end else begin
            rep_n++;
`ifdef KEYPAD_AUTOREPEAT_EN
            if (rep_n == RD || (rep_n > RD && (rep_n - RD) % RR == 0)) m_pulse = 1;
`endif
        end
    endtask

    always begin
        @(posedge clk);
        #1;
        m_pulse = 0;
        if (reset) begin
            e = 0; m_held = 0; m_code = 0; run_len = 0; none_run = 0; rep_n = 0;
        end else begin
            e++;
            if (e % FRAME == 0) model_frame(keys);
        end
        check("cols", 32'(cols), 32'(~(4'b0001 << ((e / SD) % 4)) & 4'hF));
        check("key_valid", 32'(key_valid), 32'(m_pulse));
        check("key_held", 32'(key_held), 32'(m_held));
        check("key_code", 32'(key_code), 32'(m_code));
        if (key_valid) dut_pulses++;
    end

    task automatic frames(input int n);
        repeat (FRAME * n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        keys  = 16'd0;
        @(negedge clk);
        reset = 1'b0;
        dut_pulses = 0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset_cols", 32'(cols), 32'h0000000E);
        check("reset_code", 32'(key_code), 32'd0);
        reset = 1'b0;
        dut_pulses = 0;

        // Idle scanning.
        frames(4);
        check("idle_pulses", 32'(dut_pulses), 32'd0);
        check("idle_held", 32'(key_held), 32'd0);

        // Key 6 held four frames, then released.
        do_reset();
        keys = 16'h0040;
        frames(4);
        check("k6_pulses", 32'(dut_pulses), 32'd1);
        check("k6_code", 32'(key_code), 32'd6);
        check("k6_held", 32'(key_held), 32'd1);
        keys = 16'd0;
        frames(2);
        check("k6_held_2none", 32'(key_held), 32'd1);
        frames(1);
        check("k6_released", 32'(key_held), 32'd0);
        check("k6_code_kept", 32'(key_code), 32'd6);

        // Bouncing key 6: S N S S S.
        do_reset();
        keys = 16'h0040; frames(1);
        keys = 16'd0;    frames(1);
        keys = 16'h0040; frames(2);
        check("bounce_early", 32'(dut_pulses), 32'd0);
        frames(1);
        check("bounce_pulses", 32'(dut_pulses), 32'd1);
        keys = 16'd0;
        frames(3);

        // Keys 0 and 5 together, then key 5 released.
        do_reset();
        keys = 16'h0021;
        frames(4);
        check("multi_pulses", 32'(dut_pulses), 32'd0);
        check("multi_held", 32'(key_held), 32'd0);
        keys = 16'h0001;
        frames(2);
        check("k0_early", 32'(dut_pulses), 32'd0);
        frames(1);
        check("k0_pulses", 32'(dut_pulses), 32'd1);
        check("k0_held", 32'(key_held), 32'd1);
        keys = 16'd0;
        frames(3);

        // Reset during press debounce at count 2.
        do_reset();
        keys = 16'h0040;
        frames(2);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        keys  = 16'd0;
        @(negedge clk);
        check("midrst_cols", 32'(cols), 32'h0000000E);
        check("midrst_held", 32'(key_held), 32'd0);
        reset = 1'b0;
        frames(3);
        check("midrst_pulses", 32'(dut_pulses), 32'd0);

        // Key 15 held twelve frames.
        do_reset();
        keys = 16'h8000;
        frames(12);
`ifdef KEYPAD_AUTOREPEAT_EN
        check("k15_pulses", 32'(dut_pulses), 32'd4);
`else
        check("k15_pulses", 32'(dut_pulses), 32'd1);
`endif
        check("k15_code", 32'(key_code), 32'd15);
        keys = 16'd0;
        frames(3);
        check("k15_released", 32'(key_held), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
